// File: rtl/memoir_pkg.sv
// Shared types and width helpers for the memoir free-list block.
// No logic; the defaults here match the 64-entry PIFO memory.
// Modules keep their own NUMADDR/BITADDR parameters, defaulted from here.
package memoir_pkg;

  localparam int NUMADDR = 64;
  localparam int BITADDR = 6;
  localparam int BITCNT  = BITADDR + 1;

  typedef enum logic {
    INIT  = 1'b0,
    READY = 1'b1
  } fl_state_t;

endpackage

// File: rtl/memoir_ff_freelist_if.sv
// Handshake bundle between the free-list manager and its allocator/releaser.
// Ports: alloc/alloc_vld/alloc_adr (pop), free/free_adr (push), ready,
//        free_cnt, err_uflow, err_dfree (status/error pulses).
interface memoir_ff_freelist_if #(
  parameter int BITADDR = 6
);

  logic               alloc;
  logic               alloc_vld;
  logic [BITADDR-1:0] alloc_adr;
  logic               free;
  logic [BITADDR-1:0] free_adr;
  logic               ready;
  logic [BITADDR:0]   free_cnt;
  logic               err_uflow;
  logic               err_dfree;

  // Client side: requests allocations and releases addresses.
  modport master (
    output alloc, free, free_adr,
    input  alloc_vld, alloc_adr, ready, free_cnt, err_uflow, err_dfree
  );

  // Free-list side.
  modport slave (
    input  alloc, free, free_adr,
    output alloc_vld, alloc_adr, ready, free_cnt, err_uflow, err_dfree
  );

endinterface

// File: rtl/memoir_ff_mem.sv
// Flop-based multi-port memory: NUMWPRT write ports, NUMRPRT read ports.
// Read latency 0 (FLOPOUT=0) or 1 (FLOPOUT=1); writes land on the clock edge.
// No backpressure; higher-numbered write ports win on an address collision.
// Ports: clk, wr_i/wr_adr_i/wr_dat_i per write port, rd_adr_i/rd_dat_o per read port.
module memoir_ff_mem #(
  parameter int NUMADDR = 64,
  parameter int BITADDR = 6,
  parameter int BITDATA = 6,
  parameter int NUMWPRT = 1,
  parameter int NUMRPRT = 1,
  parameter bit FLOPOUT = 1'b0
) (
  input  logic                              clk,
  input  logic [NUMWPRT-1:0]                wr_i,
  input  logic [NUMWPRT-1:0][BITADDR-1:0]   wr_adr_i,
  input  logic [NUMWPRT-1:0][BITDATA-1:0]   wr_dat_i,
  input  logic [NUMRPRT-1:0][BITADDR-1:0]   rd_adr_i,
  output logic [NUMRPRT-1:0][BITDATA-1:0]   rd_dat_o
);

  logic [BITDATA-1:0] mem_q [NUMADDR];

  always_ff @(posedge clk) begin
    for (int p = 0; p < NUMWPRT; p++) begin
      if (wr_i[p]) begin
        mem_q[wr_adr_i[p]] <= wr_dat_i[p];
      end
    end
  end

  for (genvar r = 0; r < NUMRPRT; r++) begin : g_rd
    if (FLOPOUT) begin : g_flop
      logic [BITDATA-1:0] rd_q;
      always_ff @(posedge clk) begin
        rd_q <= mem_q[rd_adr_i[r]];
      end
      assign rd_dat_o[r] = rd_q;
    end else begin : g_comb
      assign rd_dat_o[r] = mem_q[rd_adr_i[r]];
    end
  end

endmodule

// File: rtl/memoir_ff_freelist.sv
// Free-address list: self-initialises 0..NUMADDR-1, then one alloc + one free per cycle.
// Alloc is zero-latency (address decoded from registered head); errors pulse one cycle later.
// alloc_vld drops when the list is empty; illegal/early frees are dropped and flagged.
// Ports: clk, rst (sync, active-low), fl (slave side of memoir_ff_freelist_if).
module memoir_ff_freelist #(
  parameter int NUMADDR = memoir_pkg::NUMADDR,
  parameter int BITADDR = memoir_pkg::BITADDR
) (
  input  logic                 clk,
  input  logic                 rst,
  memoir_ff_freelist_if.slave  fl
);

  import memoir_pkg::*;

  localparam int                CNTW     = BITADDR + 1;
  localparam logic [CNTW-1:0]   CNT_FULL = CNTW'(NUMADDR);
  localparam logic [BITADDR-1:0] PTR_LAST = BITADDR'(NUMADDR - 1);

  fl_state_t state_q, state_d;

  logic [BITADDR-1:0] init_cnt_q, init_cnt_d;
  logic [BITADDR-1:0] head_q, head_d;
  logic [BITADDR-1:0] tail_q, tail_d;
  logic [CNTW-1:0]    count_q, count_d;
  logic [NUMADDR-1:0] bitmap_q, bitmap_d;
  logic               err_uflow_q, err_uflow_d;
  logic               err_dfree_q, err_dfree_d;

  logic               ready;
  logic               init_wr;
  logic               init_last;
  logic               grant;
  logic               free_ok;
  logic               wr_en;
  logic [BITADDR-1:0] wr_adr;
  logic [BITADDR-1:0] wr_dat;
  logic [BITADDR-1:0] rd_dat;

  function automatic logic [BITADDR-1:0] ptr_inc(input logic [BITADDR-1:0] p);
    return (p == PTR_LAST) ? '0 : p + 1'b1;
  endfunction

  // ---------------- FSM ----------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= INIT;
    end else begin
      state_q <= state_d;
    end
  end

  assign init_last = (init_cnt_q == PTR_LAST);

  always_comb begin
    state_d = state_q;
    case (state_q)
      INIT:    if (init_last) state_d = READY;
      READY:   state_d = READY;
      default: state_d = INIT;
    endcase
  end

  always_comb begin
    ready   = 1'b0;
    init_wr = 1'b0;
    case (state_q)
      INIT:    init_wr = 1'b1;
      READY:   ready   = 1'b1;
      default: ;
    endcase
  end

  // ---------------- List storage ----------------
  // The free path only writes once ready, so the init counter owns the port in INIT.
  assign wr_en  = init_wr | free_ok;
  assign wr_adr = init_wr ? init_cnt_q : tail_q;
  assign wr_dat = init_wr ? init_cnt_q : fl.free_adr;

  memoir_ff_mem #(
    .NUMADDR (NUMADDR),
    .BITADDR (BITADDR),
    .BITDATA (BITADDR),
    .NUMWPRT (1),
    .NUMRPRT (1),
    .FLOPOUT (1'b0)
  ) u_list (
    .clk      (clk),
    .wr_i     (wr_en),
    .wr_adr_i (wr_adr),
    .wr_dat_i (wr_dat),
    .rd_adr_i (head_q),
    .rd_dat_o (rd_dat)
  );

  // ---------------- Datapath ----------------
  assign grant   = fl.alloc & fl.alloc_vld;
  // Bitmap is sampled before this cycle's alloc sets it, so freeing the
  // address being granted right now is rejected.
  assign free_ok = fl.free & ready & bitmap_q[fl.free_adr];

  always_comb begin
    init_cnt_d  = init_cnt_q;
    head_d      = head_q;
    tail_d      = tail_q;
    count_d     = count_q;
    bitmap_d    = bitmap_q;
    err_uflow_d = fl.alloc & ~fl.alloc_vld;
    err_dfree_d = fl.free & ~free_ok;

    if (init_wr) begin
      init_cnt_d = init_cnt_q + 1'b1;
      if (init_last) count_d = CNT_FULL;
    end

    // A granted address has its bit clear and an accepted free has its bit
    // set, so the two bitmap updates never target the same bit.
    if (grant) begin
      head_d           = ptr_inc(head_q);
      bitmap_d[rd_dat] = 1'b1;
    end
    if (free_ok) begin
      tail_d                = ptr_inc(tail_q);
      bitmap_d[fl.free_adr] = 1'b0;
    end

    case ({grant, free_ok})
      2'b10:   count_d = count_q - 1'b1;
      2'b01:   count_d = count_q + 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      init_cnt_q  <= '0;
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      bitmap_q    <= '0;
      err_uflow_q <= 1'b0;
      err_dfree_q <= 1'b0;
    end else begin
      init_cnt_q  <= init_cnt_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      bitmap_q    <= bitmap_d;
      err_uflow_q <= err_uflow_d;
      err_dfree_q <= err_dfree_d;
    end
  end

  // ---------------- Outputs ----------------
  assign fl.ready     = ready;
  assign fl.alloc_vld = ready & (count_q != '0);
  // Storage is not reset; hold the address at 0 until init has filled it.
  assign fl.alloc_adr = ready ? rd_dat : '0;
  assign fl.free_cnt  = count_q;
  assign fl.err_uflow = err_uflow_q;
  assign fl.err_dfree = err_dfree_q;

endmodule

// File: doc/memoir_ff_freelist.md
# memoir_ff_freelist

Free-address list manager that sits directly upstream of the flop-based multi-port memory in the PIFO datapath. It hands out unused entry addresses to writers and reclaims addresses released by readers. Writers use the allocated address as their memory write address. After reset the block self-initialises so that every address 0..NUMADDR-1 is free, then serves one allocate and one free per cycle. An in-use bitmap detects illegal frees.

## Interface
- NUMADDR, 64: number of managed addresses (entries in the downstream memory).
- BITADDR, 6: address width; must equal clog2(NUMADDR).
- clk  in  1  sole clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-low reset (asserted when 0).
- alloc  in  1  pop request; honoured only when alloc_vld=1.
- alloc_vld  out  1  a free address is available at alloc_adr.
- alloc_adr  out  BITADDR  next free address; stable while alloc_vld=1 and no alloc.
- free  in  1  push request for free_adr.
- free_adr  in  BITADDR  address being released.
- ready  out  1  initialisation complete.
- free_cnt  out  BITADDR+1  number of free addresses currently held.
- err_uflow  out  1  one-cycle pulse: alloc while alloc_vld=0.
- err_dfree  out  1  one-cycle pulse: free of an address not in use, or free while ready=0.

## Operation
- Storage: circular list of NUMADDR entries of BITADDR bits, with a head pointer, a tail pointer (both BITADDR bits, wrap NUMADDR-1 -> 0) and a count (BITADDR+1 bits, range 0..NUMADDR).
- In-use bitmap: NUMADDR bits, set on a granted alloc, cleared on an accepted free.
- FSM states: INIT, READY.
  - INIT: an init counter writes value i into list entry i, one entry per cycle, for i = 0..NUMADDR-1. After the last write: head=0, tail=0, count=NUMADDR, bitmap all 0, and the FSM moves to READY.
  - READY: the terminal state; left only by reset.
- Grant: alloc_vld = ready & (count != 0). alloc_adr = list[head]. A granted alloc (alloc & alloc_vld) advances head and sets bitmap[alloc_adr].
- Free accept: a free is accepted when ready=1 and bitmap[free_adr]=1. An accepted free writes list[tail] = free_adr, advances tail and clears the bitmap bit.
- Rejected free: ready=0, or bitmap bit already 0. The free is dropped and err_dfree pulses the next cycle. There is no state change.
- Simultaneous granted alloc and accepted free: count unchanged, both pointers advance.
- Free while count=0 and alloc in the same cycle: the alloc is not granted (err_uflow) and the free is accepted. The freed address becomes visible the next cycle.
- Free of the address being allocated in the same cycle: the bitmap is sampled pre-update, so the address is not in use and the free is rejected.
- Full list (count=NUMADDR): a legal free cannot occur, because every bitmap bit is 0.
- Reset mid-operation: all state is discarded and INIT restarts from entry 0.

## Timing
- Reset values: alloc_vld=0, alloc_adr=0, ready=0, free_cnt=0, err_uflow=0, err_dfree=0, FSM=INIT, init counter=0.
- After rst is deasserted, INIT takes NUMADDR cycles. ready and alloc_vld rise in cycle NUMADDR+1 after the deassertion edge, with alloc_adr=0.
- alloc_adr and alloc_vld are decoded combinationally from registered state. Allocation is zero-latency: a request in cycle t receives the address presented in cycle t.
- A freed address is allocatable at the earliest one cycle after the free, once it reaches head.
- free_cnt is registered and reflects all events up to the previous edge.
- Error pulses are registered and assert one cycle after the offending request.

## Structure
- Shared package memoir_pkg holds:
  - typedef fl_state_t {INIT, READY};
  - the helper localparam BITCNT = BITADDR+1.
- The list storage is an instance of memoir_ff_mem with NUMWPRT=1, NUMRPRT=1, FLOPOUT=0.
  - Its write port is muxed between the init counter (INIT) and the free path (READY).
  - Its read port is addressed by head.
- The bitmap, pointers, count and FSM live in this module.

## Test plan
- Reset, then idle: ready rises after exactly 64 cycles, free_cnt=64, alloc_adr=0.
- 64 back-to-back allocs: addresses 0..63 in order, alloc_vld falls after the 64th grant, free_cnt=0. A 65th alloc pulses err_uflow.
- From empty, free 17 then free 5: the next allocs return 17 then 5 (FIFO order), and free_cnt returns to 0.
- Simultaneous alloc and free every cycle with 32 entries free: free_cnt stays at 32 and the pointers wrap past 63 without error.
- Free 9 twice after allocating it: the first free is accepted. The second pulses err_dfree and leaves free_cnt unchanged.
- Assert rst mid-stream with 10 addresses allocated: after re-init, free_cnt=64, alloc_adr=0 and the bitmap is clear (freeing 3 pulses err_dfree).
